// File: rtl/motor_dosificador.sv
// Colour dispenser motor sequencer: takes a one-hot load request, runs the
// selected channel's motor for amount x TICKS_PER_UNIT cycles, then raises
// that channel's done flag until the request is withdrawn.
module motor_dosificador #(
  parameter int W              = 8,
  parameter int TICKS_PER_UNIT = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   Motores,
  input  logic [W-1:0] amt_r,
  input  logic [W-1:0] amt_g,
  input  logic [W-1:0] amt_b,
  output logic [2:0]   flags,
  output logic [2:0]   motor_on,
  output logic         busy,
  output logic         err
);

  // Prescaler keeps at least one bit so TICKS_PER_UNIT=1 still elaborates.
  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICKS_PER_UNIT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     ch_q;
  logic [W-1:0]   cnt_q;
  logic [PW-1:0]  presc_q;

  logic           one_hot;
  logic [1:0]     req_idx;
  logic [2:0]     ch_mask;
  logic           req_ch;
  logic [W-1:0]   amt_sel;
  logic           last_tick;

  // Request decode: one-hot detection, illegal-request flag and bit index.
  always_comb begin
    one_hot = 1'b0;
    req_idx = 2'd0;
    case (Motores)
      3'b100: begin one_hot = 1'b1; req_idx = 2'd2; end
      3'b010: begin one_hot = 1'b1; req_idx = 2'd1; end
      3'b001: begin one_hot = 1'b1; req_idx = 2'd0; end
      default: ;
    endcase
    err = !one_hot && (Motores != 3'b000);
  end

  // Channel decode: bit mask and amount of the latched channel.
  always_comb begin
    ch_mask = 3'b000;
    amt_sel = '0;
    case (ch_q)
      2'd2: begin ch_mask = 3'b100; amt_sel = amt_r; end
      2'd1: begin ch_mask = 3'b010; amt_sel = amt_g; end
      2'd0: begin ch_mask = 3'b001; amt_sel = amt_b; end
      default: ;
    endcase
  end

  assign req_ch    = |(Motores & ch_mask);
  assign last_tick = (presc_q == '0) && (cnt_q == W'(1));

  // Next-state logic; any illegal request or withdrawal of the channel returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (one_hot) state_d = LOAD;
      LOAD: begin
        if (err || !req_ch)      state_d = IDLE;
        else if (amt_sel == '0)  state_d = DONE;
        else                     state_d = RUN;
      end
      RUN: begin
        if (err || !req_ch)      state_d = IDLE;
        else if (last_tick)      state_d = DONE;
      end
      DONE: if (err || !req_ch)  state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and channel only, never from Motores.
  always_comb begin
    motor_on = (state_q == RUN)  ? ch_mask : 3'b000;
    flags    = (state_q == DONE) ? ch_mask : 3'b000;
    busy     = (state_q == LOAD) || (state_q == RUN);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Channel latch, captured only when a legal request is accepted in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       ch_q <= 2'd0;
    else if (state_q == IDLE && one_hot) ch_q <= req_idx;
  end

  // Unit counter and prescaler; cleared whenever the FSM heads back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      presc_q <= '0;
    end else if (state_d == IDLE) begin
      cnt_q   <= '0;
      presc_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          cnt_q   <= amt_sel;
          presc_q <= PRESC_RELOAD;
        end
        RUN: begin
          if (presc_q == '0) begin
            presc_q <= PRESC_RELOAD;
            cnt_q   <= cnt_q - W'(1);
          end else begin
            presc_q <= presc_q - PW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          presc_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_dosificador.sv
// Self-checking bench for motor_dosificador with TICKS_PER_UNIT=4, W=8.
module tb_motor_dosificador;

  localparam int T = 4;

  logic       clk;
  logic       reset;
  logic [2:0] Motores;
  logic [7:0] amt_r, amt_g, amt_b;
  logic [2:0] flags, motor_on;
  logic       busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  motor_dosificador #(.W(8), .TICKS_PER_UNIT(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .Motores  (Motores),
    .amt_r    (amt_r),
    .amt_g    (amt_g),
    .amt_b    (amt_b),
    .flags    (flags),
    .motor_on (motor_on),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0] m;
    logic [7:0] r, g, b;
    logic [2:0] f, mo;
    logic       busy, err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic [2:0] m, input logic [7:0] r, g, b,
                               input logic [2:0] f, mo, input logic bz, er);
    vec_t v;
    v.m = m; v.r = r; v.g = g; v.b = b;
    v.f = f; v.mo = mo; v.busy = bz; v.err = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Watch a run already requested on Motores: count motor cycles until the flag rises.
  task automatic watch_run(input logic [2:0] m, input int amt, input string name);
    int on_cnt = 0;
    int bad    = 0;
    int cyc    = 0;
    int held   = 0;
    bit done   = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (motor_on == m) begin
        on_cnt++;
        if (!busy) bad++;
      end else if (motor_on != 3'b000) bad++;
      if (flags == m) done = 1;
      else if (flags != 3'b000) bad++;
    end
    check({name, "_flag_reached"}, int'(done), 1);
    check({name, "_motor_cycles"}, on_cnt, amt * T);
    check({name, "_no_glitch"}, bad, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (flags == m && motor_on == 3'b000 && !busy) held++;
    end
    check({name, "_flag_held"}, held, 3);
  endtask

  task automatic dispense(input logic [2:0] m, input int amt, input string name);
    @(negedge clk);
    Motores = m;
    watch_run(m, amt, name);
  endtask

  task automatic drop_and_check(input string name);
    @(negedge clk);
    Motores = 3'b000;
    @(negedge clk);
    check(name, int'(flags), 0);
  endtask

  initial begin
    int seen;
    int cyc;
    int bad;

    // Directed vectors: one per cycle, driven at negedge, checked 1 time unit later.
    tbl.push_back(mkv(3'b000, 0, 0, 1, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b010, 0, 0, 1, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b010, 0, 0, 1, 3'b000, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b010, 0, 0, 1, 3'b010, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b010, 0, 0, 1, 3'b010, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b000, 0, 0, 1, 3'b010, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b110, 0, 0, 1, 3'b000, 3'b000, 0, 1));
    tbl.push_back(mkv(3'b110, 0, 0, 1, 3'b000, 3'b000, 0, 1));
    tbl.push_back(mkv(3'b000, 0, 0, 1, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b001, 0, 0, 1, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b001, 0, 0, 1, 3'b000, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b001, 0, 0, 1, 3'b000, 3'b001, 1, 0));
    tbl.push_back(mkv(3'b001, 0, 0, 1, 3'b000, 3'b001, 1, 0));
    tbl.push_back(mkv(3'b001, 0, 0, 1, 3'b000, 3'b001, 1, 0));
    tbl.push_back(mkv(3'b001, 0, 0, 1, 3'b000, 3'b001, 1, 0));
    tbl.push_back(mkv(3'b001, 0, 0, 1, 3'b001, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b100, 0, 0, 1, 3'b001, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b100, 0, 0, 1, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b100, 0, 0, 1, 3'b000, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b100, 0, 0, 1, 3'b100, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b101, 0, 0, 1, 3'b100, 3'b000, 0, 1));
    tbl.push_back(mkv(3'b000, 0, 0, 1, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b010, 0, 2, 1, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b010, 0, 2, 1, 3'b000, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b010, 0, 2, 1, 3'b000, 3'b010, 1, 0));
    tbl.push_back(mkv(3'b011, 0, 2, 1, 3'b000, 3'b010, 1, 1));
    tbl.push_back(mkv(3'b011, 0, 2, 1, 3'b000, 3'b000, 0, 1));
    tbl.push_back(mkv(3'b000, 0, 2, 1, 3'b000, 3'b000, 0, 0));

    // Reset state.
    reset = 1'b0; Motores = 3'b000; amt_r = '0; amt_g = '0; amt_b = '0;
    #12;
    check("reset_outputs", int'({flags, motor_on, busy, err}), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      Motores = tbl[i].m; amt_r = tbl[i].r; amt_g = tbl[i].g; amt_b = tbl[i].b;
      #1;
      check($sformatf("vec%0d", i), int'({flags, motor_on, busy, err}),
            int'({tbl[i].f, tbl[i].mo, tbl[i].busy, tbl[i].err}));
    end

    // Normal R dispense, with amt_r changed mid-run (must be ignored).
    @(negedge clk);
    amt_r = 8'd3;
    fork
      dispense(3'b100, 3, "r_dispense");
      begin
        repeat (6) @(negedge clk);
        amt_r = 8'd9;
      end
    join
    drop_and_check("r_drop_flags");

    // Full R -> Y -> B sequence with direct handovers.
    @(negedge clk);
    amt_r = 8'd2; amt_g = 8'd1; amt_b = 8'd3;
    dispense(3'b100, 2, "seq_r");
    dispense(3'b010, 1, "seq_g");
    dispense(3'b001, 3, "seq_b");
    drop_and_check("seq_drop_flags");

    // Abort after 7 RUN cycles.
    @(negedge clk);
    amt_b = 8'd5; Motores = 3'b001;
    seen = 0; cyc = 0;
    while (seen < 7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (motor_on == 3'b001) seen++;
    end
    check("abort_run_cycles", seen, 7);
    Motores = 3'b000;
    @(negedge clk);
    check("abort_outputs", int'({flags, motor_on, busy}), 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (flags != 3'b000 || busy) bad++;
    end
    check("abort_no_flag", bad, 0);

    // Maximum amount runs to completion without underflow.
    @(negedge clk);
    amt_r = 8'd255;
    dispense(3'b100, 255, "max_amount");
    drop_and_check("max_drop_flags");

    // Asynchronous reset mid-RUN, then restart from the full amount with Motores held.
    @(negedge clk);
    amt_r = 8'd3; Motores = 3'b100;
    cyc = 0;
    while (motor_on != 3'b100 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_run_started", int'(motor_on), 3'b100);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_outputs", int'({flags, motor_on, busy}), 0);
    @(negedge clk);
    reset = 1'b1;
    watch_run(3'b100, 3, "rst_restart");
    drop_and_check("rst_drop_flags");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_dosificador.md
MOTOR_DOSIFICADOR -- requirements
Module: motor_dosificador

Interface
REQ-001 SHALL have parameter W, default 8, the width of each colour amount in units.
REQ-002 SHALL have parameter TICKS_PER_UNIT, default 1000, the number of clk cycles the motor runs per unit; the legal range is 1 to 2^16.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Motores, input, 3 bits: one-hot load request from the colour FSM (bit2=R, bit1=Y/G, bit0=B).
REQ-006 SHALL have port amt_r, input, W bits: R amount in units.
REQ-007 SHALL have port amt_g, input, W bits: Y/G amount in units.
REQ-008 SHALL have port amt_b, input, W bits: B amount in units.
REQ-009 SHALL have port flags, output, 3 bits: per-channel done flag, using the same bit order as Motores.
REQ-010 SHALL have port motor_on, output, 3 bits: per-channel motor drive, using the same bit order.
REQ-011 SHALL have port busy, output, 1 bit: high in the LOAD and RUN states.
REQ-012 SHALL have port err, output, 1 bit: high while Motores has more than one bit set.

Function
REQ-013 SHALL implement the states IDLE, LOAD, RUN and DONE, plus a 2-bit channel register ch, a W-bit unit counter and a prescaler of width ceil(log2(TICKS_PER_UNIT)).
REQ-014 In IDLE with Motores exactly one-hot, the block SHALL go to LOAD on the next edge and latch ch = index of the set bit; otherwise it SHALL stay in IDLE.
REQ-015 In LOAD, the block SHALL sample the amount selected by ch (R→amt_r, G→amt_g, B→amt_b) into the unit counter and set prescaler = TICKS_PER_UNIT-1.
REQ-016 From LOAD, if the sampled amount is 0 the block SHALL go to DONE; otherwise it SHALL go to RUN.
REQ-017 In RUN, the prescaler SHALL decrement every cycle.
REQ-018 In RUN, when the prescaler is 0 it SHALL reload TICKS_PER_UNIT-1 and the unit counter SHALL decrement.
REQ-019 In RUN, when the unit counter is 1 and the prescaler is 0, the next state SHALL be DONE.
REQ-020 The RUN dwell SHALL be exactly amount×TICKS_PER_UNIT cycles.
REQ-021 motor_on[ch] SHALL be 1 only in RUN; all other motor_on bits SHALL be 0 at all times.
REQ-022 In DONE, flags[ch] SHALL be 1 and all other flags SHALL be 0, with motor_on = 000.
REQ-023 The block SHALL stay in DONE while Motores[ch]=1 and go to IDLE on the edge after Motores[ch]=0.
REQ-024 A handover (e.g. Motores 100→010 in one cycle) SHALL give DONE→IDLE→LOAD for the new channel; flags SHALL be 000 in the IDLE cycle.
REQ-025 Abort: if Motores[ch] drops in LOAD or RUN, the block SHALL go to IDLE next edge and clear motor_on and the counters; it SHALL NOT raise a flag.
REQ-026 In any state, if Motores is not one-hot and not 000, err SHALL be 1 (combinational) and the block SHALL go to IDLE next edge with motor_on = 000.
REQ-027 The block SHALL remain in IDLE while err=1.
REQ-028 Amount inputs SHALL be sampled only in LOAD; changes during RUN SHALL be ignored.
REQ-029 motor_on, flags and busy SHALL be registered or decoded from state/ch only, with no combinational path from Motores, to keep the FSM loop glitch-free.
REQ-030 Unit-counter underflow SHALL be impossible; the maximum amount 2^W-1 SHALL run to completion.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE, ch=0, counters=0, flags=000, motor_on=000 and busy=0, including mid-RUN.
REQ-032 After reset release, the block SHALL need a fresh one-hot Motores sampled in IDLE to start a channel.
REQ-033 A Motores value already held high at reset release SHALL start a LOAD on the first edge.

Verification
REQ-034 The bench SHALL cover a normal R dispense: TICKS_PER_UNIT=4, amt_r=3, Motores=100 → busy, motor_on=100 for exactly 12 cycles, then flags=100 held; Motores=000 → flags=000 next cycle.
REQ-035 The bench SHALL cover a full R→Y→B sequence: amt_r=2, amt_g=1, amt_b=3, TICKS=4, Motores follows each flag → motor_on pulses of 8, 4 and 12 cycles, each flag rising once, in the order 100, 010, 001.
REQ-036 The bench SHALL cover a zero amount: amt_g=0, Motores=010 → motor_on stays 000 and flags=010 two cycles after the request.
REQ-037 The bench SHALL cover an abort: Motores=001 with amt_b=5, dropped to 000 after 7 RUN cycles → motor_on=000 next cycle, flags never 001, state IDLE.
REQ-038 The bench SHALL cover an illegal request: Motores=110 → err=1 the same cycle, motor_on=000, flags=000, no LOAD.
REQ-039 The bench SHALL cover reset mid-operation: reset low asynchronously during RUN → all outputs 0 before the next clk edge; after release with Motores=100, a full R run restarts from the complete amount.
